// File: rtl/gpio_bank_pkg.sv
// Shared definitions for the GPIO bank: register offsets and bus address width.
package gpio_bank_pkg;

  localparam int GPIO_ADDR_WIDTH = 3;

  // Word offsets of the eight bank registers.
  typedef enum logic [GPIO_ADDR_WIDTH-1:0] {
    GPIO_DATA_OUT   = 3'd0,
    GPIO_DIR        = 3'd1,
    GPIO_DATA_IN    = 3'd2,
    GPIO_IRQ_EN     = 3'd3,
    GPIO_EDGE_SEL   = 3'd4,
    GPIO_IRQ_STATUS = 3'd5,
    GPIO_SET_OUT    = 3'd6,
    GPIO_CLR_OUT    = 3'd7
  } gpio_reg_e;

endpackage

// File: rtl/gpio_bank_if.sv
// Core-bus slave port of the GPIO bank, as decoded by the memory controller.
interface gpio_bank_if #(
  parameter int DATA_WIDTH = 32
);
  import gpio_bank_pkg::*;

  logic                       gpio_sel;
  logic [GPIO_ADDR_WIDTH-1:0] gpio_addr;
  logic [DATA_WIDTH-1:0]      gpio_wrdata;
  logic                       gpio_wren;
  logic [DATA_WIDTH-1:0]      gpio_rddata;

  modport master (
    output gpio_sel, gpio_addr, gpio_wrdata, gpio_wren,
    input  gpio_rddata
  );

  modport slave (
    input  gpio_sel, gpio_addr, gpio_wrdata, gpio_wren,
    output gpio_rddata
  );
endinterface

// File: rtl/gpio_bank_sync_edge_detect.sv
// Per-pin input synchroniser followed by one history flop, so each pin yields a
// metastability-safe level plus single-cycle rise/fall pulses on that level.
module sync_edge_detect #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync_q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [SYNC_STAGES-1:0] chain_q;
      logic                   hist_q;

      // Shift the raw pin through the chain; the history flop holds the previous synced level.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          chain_q <= '0;
          hist_q  <= 1'b0;
        end else begin
          chain_q <= {chain_q[SYNC_STAGES-2:0], din[gi]};
          hist_q  <= chain_q[SYNC_STAGES-1];
        end
      end

      assign sync_q[gi] = chain_q[SYNC_STAGES-1];
      assign rise[gi]   = chain_q[SYNC_STAGES-1] & ~hist_q;
      assign fall[gi]   = ~chain_q[SYNC_STAGES-1] & hist_q;
    end
  endgenerate

endmodule

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: register file, combinational read mux, edge-interrupt
// status with write-one-to-clear, and the masked level-high interrupt output.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int GPIO_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  gpio_bank_if.slave            bus,
  input  logic [GPIO_WIDTH-1:0] gpio_port_in,
  output logic [GPIO_WIDTH-1:0] gpio_port_out,
  output logic [GPIO_WIDTH-1:0] gpio_port_oe,
  output logic                  gpio_irq
);

  logic [GPIO_WIDTH-1:0] data_out_q,   data_out_d;
  logic [GPIO_WIDTH-1:0] dir_q,        dir_d;
  logic [GPIO_WIDTH-1:0] irq_en_q,     irq_en_d;
  logic [GPIO_WIDTH-1:0] edge_sel_q,   edge_sel_d;
  logic [GPIO_WIDTH-1:0] irq_status_q, irq_status_d;

  logic [GPIO_WIDTH-1:0] sync_level;
  logic [GPIO_WIDTH-1:0] sync_rise;
  logic [GPIO_WIDTH-1:0] sync_fall;
  logic [GPIO_WIDTH-1:0] edge_hit;
  logic [GPIO_WIDTH-1:0] wr_data;
  logic [GPIO_WIDTH-1:0] w1c_mask;
  logic [GPIO_WIDTH-1:0] rd_val;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  wr_en;

  // Upper write-data bits beyond the pin count are intentionally discarded.
  logic unused_wrdata;
  assign unused_wrdata = ^bus.gpio_wrdata;

  sync_edge_detect #(
    .WIDTH       (GPIO_WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (gpio_port_in),
    .sync_q (sync_level),
    .rise   (sync_rise),
    .fall   (sync_fall)
  );

  assign wr_en   = bus.gpio_sel & bus.gpio_wren;
  assign wr_data = bus.gpio_wrdata[GPIO_WIDTH-1:0];

  // Each pin reports only the transition direction chosen by its EDGE_SEL bit.
  assign edge_hit = (sync_rise & ~edge_sel_q) | (sync_fall & edge_sel_q);

  // Register-file next state; a fresh edge is OR-ed in after W1C so set wins a collision.
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irq_en_d   = irq_en_q;
    edge_sel_d = edge_sel_q;
    w1c_mask   = '0;
    if (wr_en) begin
      case (gpio_reg_e'(bus.gpio_addr))
        GPIO_DATA_OUT:   data_out_d = wr_data;
        GPIO_DIR:        dir_d      = wr_data;
        GPIO_IRQ_EN:     irq_en_d   = wr_data;
        GPIO_EDGE_SEL:   edge_sel_d = wr_data;
        GPIO_IRQ_STATUS: w1c_mask   = wr_data;
        GPIO_SET_OUT:    data_out_d = data_out_q | wr_data;
        GPIO_CLR_OUT:    data_out_d = data_out_q & ~wr_data;
        default:         ;
      endcase
    end
    irq_status_d = (irq_status_q & ~w1c_mask) | edge_hit;
  end

  // Register-file state, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q   <= '0;
      dir_q        <= '0;
      irq_en_q     <= '0;
      edge_sel_q   <= '0;
      irq_status_q <= '0;
    end else begin
      data_out_q   <= data_out_d;
      dir_q        <= dir_d;
      irq_en_q     <= irq_en_d;
      edge_sel_q   <= edge_sel_d;
      irq_status_q <= irq_status_d;
    end
  end

  // Side-effect-free read mux; unselected bus and write-only offsets read as zero.
  always_comb begin
    rd_val = '0;
    if (bus.gpio_sel) begin
      case (gpio_reg_e'(bus.gpio_addr))
        GPIO_DATA_OUT:   rd_val = data_out_q;
        GPIO_DIR:        rd_val = dir_q;
        GPIO_DATA_IN:    rd_val = sync_level;
        GPIO_IRQ_EN:     rd_val = irq_en_q;
        GPIO_EDGE_SEL:   rd_val = edge_sel_q;
        GPIO_IRQ_STATUS: rd_val = irq_status_q;
        default:         rd_val = '0;
      endcase
    end
  end

  // Zero-extend the pin-wide value onto the bus.
  always_comb begin
    rd_word                 = '0;
    rd_word[GPIO_WIDTH-1:0] = rd_val;
  end

  assign bus.gpio_rddata = rd_word;
  assign gpio_port_out   = data_out_q;
  assign gpio_port_oe    = dir_q;
  assign gpio_irq        = |(irq_status_q & irq_en_q);

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: directed scenarios plus a randomized run,
// all checked against a level-history reference model of the register map.
module tb_gpio_bank;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gpio_bank_if #(.DATA_WIDTH(32)) bus8 ();
  gpio_bank_if #(.DATA_WIDTH(32)) bus4 ();

  logic [7:0] pins8;
  logic [7:0] port_out8, port_oe8;
  logic       irq8;
  logic [3:0] pins4;
  logic [3:0] port_out4, port_oe4;
  logic       irq4;

  gpio_bank #(.GPIO_WIDTH(8), .SYNC_STAGES(SYNC), .DATA_WIDTH(32)) dut8 (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus8),
    .gpio_port_in  (pins8),
    .gpio_port_out (port_out8),
    .gpio_port_oe  (port_oe8),
    .gpio_irq      (irq8)
  );

  gpio_bank #(.GPIO_WIDTH(4), .SYNC_STAGES(SYNC), .DATA_WIDTH(32)) dut4 (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus4),
    .gpio_port_in  (pins4),
    .gpio_port_out (port_out4),
    .gpio_port_oe  (port_oe4),
    .gpio_irq      (irq4)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: register values plus a history of sampled pin words (newest first).
  logic [7:0] m_out, m_dir, m_en, m_es, m_st;
  logic [7:0] samp[$];
  logic [31:0] rd_val;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out = '0; m_dir = '0; m_en = '0; m_es = '0; m_st = '0;
    samp = {};
    repeat (8) samp.push_back(8'h00);
  endtask

  // Synced level seen by software is the pin word sampled SYNC-1 edges ago.
  function automatic logic [7:0] model_data_in();
    return samp[SYNC-1];
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {24'h0, m_out};
      3'd1: return {24'h0, m_dir};
      3'd2: return {24'h0, samp[SYNC-1]};
      3'd3: return {24'h0, m_en};
      3'd4: return {24'h0, m_es};
      3'd5: return {24'h0, m_st};
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge of the reference model, using the inputs held across the edge.
  task automatic model_step();
    logic [7:0] now_lvl, prev_lvl, hits, wd;
    samp.push_front(pins8);
    now_lvl  = samp[SYNC];
    prev_lvl = samp[SYNC+1];
    hits = '0;
    for (int i = 0; i < 8; i++) begin
      if (!m_es[i] && !prev_lvl[i] && now_lvl[i]) hits[i] = 1'b1;
      if (m_es[i] && prev_lvl[i] && !now_lvl[i])  hits[i] = 1'b1;
    end
    wd = bus8.gpio_wrdata[7:0];
    if (bus8.gpio_sel && bus8.gpio_wren) begin
      case (bus8.gpio_addr)
        3'd0: m_out = wd;
        3'd1: m_dir = wd;
        3'd3: m_en  = wd;
        3'd4: m_es  = wd;
        3'd5: m_st  = m_st & ~wd;
        3'd6: m_out = m_out | wd;
        3'd7: m_out = m_out & ~wd;
        default: ;
      endcase
    end
    m_st = m_st | hits;
    while (samp.size() > 8) void'(samp.pop_back());
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_val("port_out", {24'h0, port_out8}, {24'h0, m_out});
    check_val("port_oe", {24'h0, port_oe8}, {24'h0, m_dir});
    check_val("irq", {31'h0, irq8}, {31'h0, |(m_st & m_en)});
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus8.gpio_sel = 1'b1; bus8.gpio_wren = 1'b1; bus8.gpio_addr = a; bus8.gpio_wrdata = d;
    tick();
    bus8.gpio_wren = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    bus8.gpio_sel = 1'b1; bus8.gpio_wren = 1'b0; bus8.gpio_addr = a;
    tick();
    rd_val = bus8.gpio_rddata;
    check_val($sformatf("rd_model[%0d]", a), rd_val, model_read(a));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_val("rst_port_out", {24'h0, port_out8}, 32'h0);
    check_val("rst_port_oe", {24'h0, port_oe8}, 32'h0);
    check_val("rst_irq", {31'h0, irq8}, 32'h0);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    bus8.gpio_sel = 1'b0; bus8.gpio_wren = 1'b0; bus8.gpio_addr = '0; bus8.gpio_wrdata = '0;
    bus4.gpio_sel = 1'b0; bus4.gpio_wren = 1'b0; bus4.gpio_addr = '0; bus4.gpio_wrdata = '0;
    pins8 = 8'h00;
    pins4 = 4'h0;
    model_reset();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: reset in the middle of activity
    wr(3'd3, 32'hFF);
    wr(3'd1, 32'h5A);
    pins8 = 8'hFF;
    repeat (4) tick();
    pins8 = 8'h00;
    do_reset();
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      check_val($sformatf("reset_reg[%0d]", a), rd_val, 32'h0);
    end
    bus8.gpio_sel = 1'b0; bus8.gpio_addr = 3'd5;
    #1;
    check_val("unselected_read", bus8.gpio_rddata, 32'h0);

    // 2: direction and output, then atomic set/clear
    wr(3'd1, 32'hF0);
    wr(3'd0, 32'hA5);
    check_val("oe_f0", {24'h0, port_oe8}, 32'hF0);
    check_val("out_a5", {24'h0, port_out8}, 32'hA5);
    wr(3'd6, 32'h02);
    check_val("set_out", {24'h0, port_out8}, 32'hA7);
    wr(3'd7, 32'h81);
    check_val("clr_out", {24'h0, port_out8}, 32'h26);
    rd(3'd6);
    check_val("wo_read6", rd_val, 32'h0);

    // 3: synchroniser latency
    bus8.gpio_addr = 3'd2;
    pins8 = 8'h3C;
    rd(3'd2);
    check_val("sync_edge_k", rd_val, 32'h00);
    rd(3'd2);
    check_val("sync_edge_k1", rd_val, 32'h3C);
    wr(3'd2, 32'hFF);
    rd(3'd2);
    check_val("data_in_ro", rd_val, 32'h3C);
    pins8 = 8'h00;
    repeat (4) tick();
    wr(3'd5, 32'hFF);

    // 4: rising interrupt, clear, and ignored falling edge
    wr(3'd3, 32'h01);
    wr(3'd4, 32'h00);
    pins8 = 8'h01;
    rd(3'd5);
    rd(3'd5);
    check_val("rise_k1", rd_val, 32'h00);
    rd(3'd5);
    check_val("rise_k2", rd_val, 32'h01);
    check_val("rise_irq", {31'h0, irq8}, 32'h1);
    wr(3'd5, 32'h01);
    check_val("w1c_irq", {31'h0, irq8}, 32'h0);
    pins8 = 8'h00;
    repeat (4) tick();
    rd(3'd5);
    check_val("fall_ignored", rd_val, 32'h00);

    // 5: falling edge with the interrupt masked, then unmasked
    wr(3'd3, 32'h00);
    wr(3'd4, 32'h80);
    pins8 = 8'h80;
    repeat (4) tick();
    wr(3'd5, 32'hFF);
    pins8 = 8'h00;
    repeat (3) tick();
    rd(3'd5);
    check_val("fall_status", rd_val, 32'h80);
    check_val("masked_irq", {31'h0, irq8}, 32'h0);
    wr(3'd3, 32'h80);
    check_val("unmask_irq", {31'h0, irq8}, 32'h1);

    // 6: clear colliding with a new edge on the same bit, then width truncation
    wr(3'd4, 32'h00);
    wr(3'd5, 32'hFF);
    pins8 = 8'h08;
    tick();
    tick();
    wr(3'd5, 32'h08);
    rd(3'd5);
    check_val("collision_set_wins", rd_val, 32'h08);
    bus4.gpio_sel = 1'b1; bus4.gpio_wren = 1'b1; bus4.gpio_addr = 3'd0; bus4.gpio_wrdata = 32'hFF;
    tick();
    bus4.gpio_wren = 1'b0;
    #1;
    check_val("w4_read", bus4.gpio_rddata, 32'h0F);
    check_val("w4_port_out", {28'h0, port_out4}, 32'h0F);
    bus4.gpio_sel = 1'b0;

    // Randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) pins8 = 8'($urandom);
      if (it % 131 == 70) begin
        do_reset();
      end else if (op < 4) begin
        wr(3'($urandom_range(0, 7)), $urandom);
      end else if (op < 9) begin
        rd(3'($urandom_range(0, 7)));
      end else begin
        bus8.gpio_sel = 1'b0;
        bus8.gpio_addr = 3'($urandom_range(0, 7));
        tick();
        check_val("rand_unselected", bus8.gpio_rddata, 32'h0);
      end
    end
    rd(3'd2);
    check_val("final_data_in", rd_val, {24'h0, model_data_in()});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
